// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two requester ports, the shared SRAM-style port and the grant counters.
// The arbiter takes the slave modport; the requester/SRAM side takes the master modport.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [STRB_W-1:0] m0_wstrb;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] s_addra;
    logic [DATA_W-1:0] s_dina;
    logic [DATA_W-1:0] s_douta;
    logic              s_ena;
    logic [STRB_W-1:0] s_wea;

    logic [CNT_W-1:0]  m0_gnt_cnt;
    logic [CNT_W-1:0]  m1_gnt_cnt;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_wdata, m1_wstrb,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_addra, s_dina, s_ena, s_wea,
        input  s_douta,
        output m0_gnt_cnt, m1_gnt_cnt
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_wdata, m1_wstrb,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_addra, s_dina, s_ena, s_wea,
        output s_douta,
        input  m0_gnt_cnt, m1_gnt_cnt
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master round-robin arbiter in front of one single-cycle SRAM-style port.
// Grant is combinational; the response is routed back one cycle later to the accepted master.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    bus
);
    logic             w_req0;
    logic             w_req1;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_win;
    logic             w_any;

    logic             r_last_gnt;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic             r_resp_rd;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Gating with rst_n keeps every request-driven output quiet while reset is held.
    assign w_req0 = rst_n & bus.m0_req;
    assign w_req1 = rst_n & bus.m1_req;
    assign w_gnt0 = w_req0 & (~w_req1 | r_last_gnt);
    assign w_gnt1 = w_req1 & (~w_req0 | ~r_last_gnt);
    assign w_any  = w_gnt0 | w_gnt1;
    assign w_win  = w_gnt1;

    assign bus.m0_gnt = w_gnt0;
    assign bus.m1_gnt = w_gnt1;

    always_comb begin
        bus.s_ena   = 1'b0;
        bus.s_addra = '0;
        bus.s_dina  = '0;
        bus.s_wea   = '0;
        if (w_gnt0) begin
            bus.s_ena   = 1'b1;
            bus.s_addra = bus.m0_addr;
            bus.s_dina  = bus.m0_wdata;
            bus.s_wea   = bus.m0_wstrb;
        end else if (w_gnt1) begin
            bus.s_ena   = 1'b1;
            bus.s_addra = bus.m1_addr;
            bus.s_dina  = bus.m1_wdata;
            bus.s_wea   = bus.m1_wstrb;
        end
    end

    always_comb begin
        bus.m0_rvalid = r_resp_valid & ~r_resp_id;
        bus.m1_rvalid = r_resp_valid & r_resp_id;
        bus.m0_rdata  = '0;
        bus.m1_rdata  = '0;
        if (bus.m0_rvalid && r_resp_rd) bus.m0_rdata = bus.s_douta;
        if (bus.m1_rvalid && r_resp_rd) bus.m1_rdata = bus.s_douta;
    end

    assign bus.m0_gnt_cnt = r_cnt0;
    assign bus.m1_gnt_cnt = r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt   <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_rd    <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            r_resp_valid <= w_any;
            if (w_any) begin
                r_last_gnt <= w_win;
                r_resp_id  <= w_win;
                r_resp_rd  <= w_gnt0 ? (bus.m0_wstrb == '0) : (bus.m1_wstrb == '0);
            end
            // Counters saturate at all-ones instead of wrapping.
            if (w_gnt0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_gnt1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter, built with 4-bit grant counters to reach saturation.
module tb_sram_port_arbiter;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.m0_req   = 1'b0;
        bus.m0_addr  = '0;
        bus.m0_wdata = '0;
        bus.m0_wstrb = '0;
        bus.m1_req   = 1'b0;
        bus.m1_addr  = '0;
        bus.m1_wdata = '0;
        bus.m1_wstrb = '0;
        bus.s_douta  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_inputs();
        #1;
        chk("rst_m0_gnt", 64'(bus.m0_gnt), 64'd0);
        chk("rst_s_ena", 64'(bus.s_ena), 64'd0);
        chk("rst_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
        chk("rst_m1_rvalid", 64'(bus.m1_rvalid), 64'd0);
        chk("rst_cnt0", 64'(bus.m0_gnt_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: lone m0 read
        @(negedge clk);
        bus.m0_req  = 1'b1;
        bus.m0_addr = 64'h6000_0000;
        #1;
        chk("t1_m0_gnt", 64'(bus.m0_gnt), 64'd1);
        chk("t1_m1_gnt", 64'(bus.m1_gnt), 64'd0);
        chk("t1_s_ena", 64'(bus.s_ena), 64'd1);
        chk("t1_s_wea", 64'(bus.s_wea), 64'd0);
        chk("t1_s_addra", bus.s_addra, 64'h6000_0000);
        @(negedge clk);
        bus.m0_req  = 1'b0;
        bus.s_douta = 64'h0000_6000_0000_0000;
        #1;
        chk("t1_m0_rvalid", 64'(bus.m0_rvalid), 64'd1);
        chk("t1_m0_rdata", bus.m0_rdata, 64'h0000_6000_0000_0000);
        chk("t1_m1_rvalid", 64'(bus.m1_rvalid), 64'd0);
        chk("t1_cnt0", 64'(bus.m0_gnt_cnt), 64'd1);

        // 2: both request for 6 cycles from a fresh reset
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.m0_req  = 1'b1;
            bus.m1_req  = 1'b1;
            bus.s_douta = 64'(100 + i);
            #1;
            chk($sformatf("t2_m0_gnt_%0d", i), 64'(bus.m0_gnt), 64'((i % 2) == 0));
            chk($sformatf("t2_m1_gnt_%0d", i), 64'(bus.m1_gnt), 64'((i % 2) == 1));
            if (i > 0) begin
                chk($sformatf("t2_m0_rv_%0d", i), 64'(bus.m0_rvalid), 64'((i % 2) == 1));
                chk($sformatf("t2_m1_rv_%0d", i), 64'(bus.m1_rvalid), 64'((i % 2) == 0));
            end
        end
        @(negedge clk);
        bus.m0_req  = 1'b0;
        bus.m1_req  = 1'b0;
        bus.s_douta = 64'h55;
        #1;
        chk("t2_m1_rv_last", 64'(bus.m1_rvalid), 64'd1);
        chk("t2_m1_rdata_last", bus.m1_rdata, 64'h55);
        chk("t2_m0_rdata_last", bus.m0_rdata, 64'd0);
        chk("t2_cnt0", 64'(bus.m0_gnt_cnt), 64'd3);
        chk("t2_cnt1", 64'(bus.m1_gnt_cnt), 64'd3);

        // 3: m1 byte write
        @(negedge clk);
        bus.m1_req   = 1'b1;
        bus.m1_addr  = 64'h6000_0000;
        bus.m1_wdata = 64'h41;
        bus.m1_wstrb = 8'h01;
        #1;
        chk("t3_m1_gnt", 64'(bus.m1_gnt), 64'd1);
        chk("t3_s_wea", 64'(bus.s_wea), 64'h01);
        chk("t3_s_dina", bus.s_dina, 64'h41);
        chk("t3_s_addra", bus.s_addra, 64'h6000_0000);
        @(negedge clk);
        idle_inputs();
        bus.s_douta = 64'hDEAD_BEEF;
        #1;
        chk("t3_m1_rvalid", 64'(bus.m1_rvalid), 64'd1);
        chk("t3_m1_rdata", bus.m1_rdata, 64'd0);
        chk("t3_m0_rvalid", 64'(bus.m0_rvalid), 64'd0);
        chk("t3_cnt1", 64'(bus.m1_gnt_cnt), 64'd4);

        // 6: idle cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t6_s_ena_%0d", i), 64'(bus.s_ena), 64'd0);
            chk($sformatf("t6_s_wea_%0d", i), 64'(bus.s_wea), 64'd0);
            chk($sformatf("t6_rv_%0d", i), 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        end
        chk("t6_cnt0", 64'(bus.m0_gnt_cnt), 64'd3);
        chk("t6_cnt1", 64'(bus.m1_gnt_cnt), 64'd4);

        // 4: 17 m0 grants from 3 must pin the 4-bit counter at 0xF
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.m0_req = 1'b1;
            #1;
            if (i == 12) chk("t4_cnt0_at_max", 64'(bus.m0_gnt_cnt), 64'hF);
        end
        @(negedge clk);
        bus.m0_req = 1'b0;
        #1;
        chk("t4_cnt0_sat", 64'(bus.m0_gnt_cnt), 64'hF);
        chk("t4_cnt1", 64'(bus.m1_gnt_cnt), 64'd4);

        // 5: reset the cycle after a grant to m1
        @(negedge clk);
        bus.m0_req   = 1'b1;
        bus.m1_req   = 1'b1;
        bus.m1_wstrb = 8'hFF;
        bus.m0_wstrb = 8'hFF;
        #1;
        chk("t5_m1_gnt", 64'(bus.m1_gnt), 64'd1);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.s_douta = 64'h1234;
        #1;
        chk("t5_rst_rv", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        chk("t5_rst_gnt", 64'({bus.m0_gnt, bus.m1_gnt}), 64'd0);
        chk("t5_rst_ena", 64'(bus.s_ena), 64'd0);
        chk("t5_rst_wea", 64'(bus.s_wea), 64'd0);
        chk("t5_rst_rdata", bus.m1_rdata, 64'd0);
        chk("t5_rst_cnt0", 64'(bus.m0_gnt_cnt), 64'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.m0_wstrb = 8'h00;
        #1;
        chk("t5_post_rv", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
        chk("t5_post_m0_gnt", 64'(bus.m0_gnt), 64'd1);
        chk("t5_post_m1_gnt", 64'(bus.m1_gnt), 64'd0);
        @(negedge clk);
        idle_inputs();
        bus.s_douta = 64'h77;
        #1;
        chk("t5_m0_rvalid", 64'(bus.m0_rvalid), 64'd1);
        chk("t5_m0_rdata", bus.m0_rdata, 64'h77);
        chk("t5_m1_rvalid", 64'(bus.m1_rvalid), 64'd0);
        chk("t5_cnt0", 64'(bus.m0_gnt_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
